// File: rtl/color_rr_arb_pkg.sv
// color_rr_arb_pkg: shared FSM state type and size limit for color_rr_arb
package color_rr_arb_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  localparam int MAX_N_REQ = 8;
endpackage

// File: rtl/color_rr_arb_rr_pick.sv
// rr_pick: combinational round-robin search starting just after ptr, wrapping around
module rr_pick #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scan farthest-first so the nearest requester after ptr overwrites the rest.
  always_comb begin
    grant = '0;
    idx = '0;
    any = |req;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/color_rr_arb.sv
// color_rr_arb: round-robin N-way beat arbiter with one-cycle output register.
// Define COLOR_RR_ARB_PKTLOCK_EN to hold the grant for a whole packet (until i_last).
module color_rr_arb
  import color_rr_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_cg,
  input  logic [N_REQ-1:0]       i_valid,
  input  logic [N_REQ*WIDTH-1:0] i_data,
  input  logic [N_REQ-1:0]       i_last,
  output logic [N_REQ-1:0]       o_ready,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_last,
  output logic [IW-1:0]          o_idx,
  input  logic                   i_ready
);
  logic [IW-1:0] ptr, pick_idx, sel;
  logic [N_REQ-1:0] pick_grant, grant;
  logic pick_any, any, load_en;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req(i_valid),
    .ptr(ptr),
    .grant(pick_grant),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign load_en = i_cg && (!o_valid || i_ready);
`ifdef COLOR_RR_ARB_PKTLOCK_EN
  state_t state;
  logic locked;
  // ptr always names the last winner, so it doubles as the locked requester.
  assign locked = state == LOCKED;
  assign grant = locked ? (N_REQ'(i_valid[ptr]) << ptr) : pick_grant;
  assign any = locked ? i_valid[ptr] : pick_any;
  assign sel = locked ? ptr : pick_idx;
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else if (load_en && any) state <= i_last[sel] ? IDLE : LOCKED;
  end
`else
  assign grant = pick_grant;
  assign any = pick_any;
  assign sel = pick_idx;
`endif
  assign o_ready = (load_en && i_rstn) ? grant : '0;
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_last <= 1'b0;
      o_idx <= '0;
      ptr <= IW'(N_REQ - 1);
    end else if (load_en) begin
      o_valid <= any;
      if (any) begin
        o_data <= i_data[sel*WIDTH +: WIDTH];
        o_last <= i_last[sel];
        o_idx <= sel;
        ptr <= sel;
      end
    end
  end
endmodule
